load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the execute stage and the word-addressed data RAM and performs RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW). The RAM writes only whole 32-bit words and reads combinationally, so the unit does read-modify-write for sub-word stores, lane extraction and sign/zero extension for loads, and misalignment checking. It exposes a valid/ready request handshake to the pipeline and a registered, one-cycle `done` pulse carrying the result.

## Interface
- No parameters. Widths come from `types_pkg`: `DATA_WIDTH` = 32 and `DATA_BUS`.
- `clk` in, 1: the single clock, rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `req_valid` in, 1: a request is present and held until accepted.
- `req_ready` out, 1: the unit accepts a request this cycle. Asserted only in IDLE.
- `req_we` in, 1: 1 = store, 0 = load.
- `funct3` in, 3: RV32I width/sign code.
- `addr` in, `DATA_BUS`: byte address.
- `wdata` in, `DATA_BUS`: store data, right-aligned.
- `rdata` out, `DATA_BUS`: load result, registered.
- `done` out, 1: one-cycle completion pulse.
- `err` out, 1: misaligned or illegal `funct3`. Valid only when `done` = 1.
- `mem_we` out, 1: RAM write enable.
- `mem_a` out, `DATA_BUS`: RAM address, always word-aligned (bits [1:0] = 0).
- `mem_wd` out, `DATA_BUS`: RAM write data.
- `mem_rd` in, `DATA_BUS`: RAM combinational read data.

## Operation
- States are IDLE, RMW_WRITE and RESP. A request is accepted when `req_valid && req_ready`. At acceptance the unit captures `addr`, `funct3`, `wdata` and `req_we`.
- Error check at acceptance:
  - Illegal load `funct3`: 3, 6, 7.
  - Illegal store `funct3`: any value > 2.
  - Misaligned: halfword access with `addr[0]` = 1; word access with `addr[1:0]` ≠ 0.
  - An error request performs no write. It goes IDLE→RESP with `err` = 1 and `rdata` = 0.
- Load: in the accept cycle, `mem_a` = {`addr[31:2]`, 2'b00}. The lane is selected and extended from `mem_rd`, registered into `rdata`, and the unit goes to RESP.
  - Byte lane = `addr[1:0]`. Halfword lane = `addr[1]`. Byte order is little-endian.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- SW: in the accept cycle, `mem_we` = 1 and `mem_wd` = `wdata`. Next state is RESP.
- SB/SH:
  - Accept cycle: the unit reads `mem_rd` into a hold register and goes to RMW_WRITE.
  - RMW_WRITE: `mem_a` = captured word address, `mem_we` = 1, and `mem_wd` = hold word with the target lane(s) replaced by `wdata[7:0]` / `wdata[15:0]`. Next state is RESP.
- RESP: `done` = 1 for exactly one cycle, then the unit returns to IDLE. `rdata` keeps its value until the next load completes. Stores leave `rdata` unchanged.
- `mem_we` is 0 in every other state/cycle. `mem_we` is gated by `!rst`: no RAM write may occur in a cycle where `rst` = 1.

## Timing
- Reset values: state IDLE, `rdata` = 0, `done` = 0, `err` = 0, hold register = 0. Combinational outputs in IDLE with no request: `mem_we` = 0 and `req_ready` = 1.
- Latency from the accept edge to `done` high:
  - Load, SW, or error: 1 cycle.
  - SB/SH: 2 cycles.
- Throughput: one request per 2 cycles (3 cycles for sub-word stores). `req_ready` = 0 in RMW_WRITE and RESP. A held `req_valid` is accepted in the first cycle back in IDLE.
- Asserting `rst` in RMW_WRITE aborts the RMW: no write occurs, and the next cycle is IDLE with `done` = 0.
- No address wrap handling is needed: the RAM ignores upper address bits.

## Structure
- `types_pkg` gains:
  - `lsu_state_t` enum.
  - `funct3` constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - `DATA_BUS` and `DATA_WIDTH`, already shared.
- One natural sub-module, `load_extend`, which is combinational: inputs `mem_rd`, `addr[1:0]`, `funct3`; output extended word. The store lane-merge logic stays inline.

## Test plan
- Preload word 0x0000_0010 = 0x8070_60F0.
  - LB @0x10 → `rdata` = 0xFFFF_FFF0 and `done` one cycle after accept.
  - LBU @0x13 → `rdata` = 0x0000_0080.
- On the same word, LH @0x12 → `rdata` = 0xFFFF_8070; LHU @0x12 → `rdata` = 0x0000_8070.
- SB `wdata` = 0x0000_00AB @0x11:
  - `mem_we` is high only in the cycle after accept, with `mem_wd` = 0x8070_ABF0.
  - `done` goes high 2 cycles after accept.
  - A following LW @0x10 returns 0x8070_ABF0.
- SW 0x1234_5678 @0x20 → `mem_we` is high in the accept cycle, and a following LW @0x20 returns 0x1234_5678.
- Error cases, each giving `err` = 1 with `done`, no `mem_we` in any cycle, and `rdata` = 0:
  - SH @0x21.
  - LW @0x22.
  - Load with `funct3` = 3.
- Assert `rst` during the RMW_WRITE of SH @0x10 → word 0x10 is unchanged, and the following cycle shows `req_ready` = 1 and `done` = 0.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types and constants for the load/store path: bus widths, the
// load/store unit state encoding, RV32I funct3 width codes and the
// request legality check used at acceptance time.
package types_pkg;

  localparam int DATA_WIDTH = 32;
  // MSB index of a data/address bus, so ports read [DATA_BUS:0]
  localparam int DATA_BUS   = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    LSU_IDLE      = 2'd0,
    LSU_RMW_WRITE = 2'd1,
    LSU_RESP      = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when a request must be rejected: an unknown width code for its
  // direction, or an address not aligned to the access size. funct3[1:0]
  // encodes the size for both signed and unsigned loads.
  function automatic logic lsu_req_error(input logic       we,
                                         input logic [2:0] f3,
                                         input logic [1:0] byte_off);
    logic illegal;
    logic misaligned;
    if (we) begin
      illegal = (f3 > F3_W);
    end else begin
      illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end
    misaligned = ((f3[1:0] == 2'b01) && byte_off[0]) ||
                 ((f3[1:0] == 2'b10) && (byte_off != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane extraction: picks the byte/halfword addressed inside a
// little-endian RAM word and sign- or zero-extends it to a full word.
module load_extend
  import types_pkg::*;
(
  input  logic [DATA_BUS:0] mem_rd,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  output logic [DATA_BUS:0] ext_data
);

  logic [7:0]  lane_b [4];
  logic [15:0] lane_h [2];
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Slice the word into its byte and halfword lanes (lane 0 = bits [7:0])
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign lane_b[gi] = mem_rd[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign lane_h[gi] = mem_rd[16*gi +: 16];
    end
  endgenerate

  assign sel_b = lane_b[addr_lo];
  assign sel_h = lane_h[addr_lo[1]];

  // Extend the selected lane according to the width/sign code
  always_comb begin
    ext_data = mem_rd;
    case (funct3)
      F3_B:    ext_data = {{(DATA_WIDTH-8){sel_b[7]}}, sel_b};
      F3_H:    ext_data = {{(DATA_WIDTH-16){sel_h[15]}}, sel_h};
      F3_BU:   ext_data = {{(DATA_WIDTH-8){1'b0}}, sel_b};
      F3_HU:   ext_data = {{(DATA_WIDTH-16){1'b0}}, sel_h};
      default: ext_data = mem_rd;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide, combinational-read RAM.
// Loads and full-word stores complete in one RAM cycle; byte/halfword
// stores read the word, then write it back with the target lane(s)
// replaced. Every request ends with a one-cycle registered done pulse.
module load_store_unit
  import types_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [DATA_BUS:0] addr,
  input  logic [DATA_BUS:0] wdata,
  output logic [DATA_BUS:0] rdata,
  output logic              done,
  output logic              err,
  output logic              mem_we,
  output logic [DATA_BUS:0] mem_a,
  output logic [DATA_BUS:0] mem_wd,
  input  logic [DATA_BUS:0] mem_rd
);

  lsu_state_t        state_reg;
  logic [DATA_BUS:0] addr_reg;
  logic [2:0]        funct3_reg;
  logic [15:0]       wdata_lo_reg;
  logic [DATA_BUS:0] hold_reg;
  logic [DATA_BUS:0] rdata_reg;
  logic              done_reg;
  logic              err_reg;

  logic              accept;
  logic              req_err;
  logic [DATA_BUS:0] ext_data;
  logic [DATA_BUS:0] merge_data;

  assign req_ready = (state_reg == LSU_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_err   = lsu_req_error(req_we, funct3, addr[1:0]);

  assign rdata = rdata_reg;
  assign done  = done_reg;
  assign err   = err_reg;

  // Load lane selection works on the live request during the accept cycle
  load_extend u_load_extend (
    .mem_rd   (mem_rd),
    .addr_lo  (addr[1:0]),
    .funct3   (funct3),
    .ext_data (ext_data)
  );

  // Sub-word store merge: each byte lane takes store data when hit,
  // otherwise keeps the word read back during the accept cycle
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      logic byte_hit;
      logic half_hit;
      assign byte_hit = (funct3_reg == F3_B) && (addr_reg[1:0] == 2'(gi));
      assign half_hit = (funct3_reg == F3_H) && (addr_reg[1] == 1'(gi / 2));
      assign merge_data[8*gi +: 8] = byte_hit ? wdata_lo_reg[7:0] :
                                     half_hit ? wdata_lo_reg[8*(gi % 2) +: 8] :
                                                hold_reg[8*gi +: 8];
    end
  endgenerate

  // RAM port: live request address in IDLE, captured address during the
  // RMW write; writes are suppressed whenever reset is asserted
  always_comb begin
    mem_we = 1'b0;
    mem_a  = {addr[DATA_BUS:2], 2'b00};
    mem_wd = wdata;
    case (state_reg)
      LSU_IDLE: begin
        if (accept && req_we && !req_err && (funct3 == F3_W)) begin
          mem_we = 1'b1;
        end
      end
      LSU_RMW_WRITE: begin
        mem_a  = {addr_reg[DATA_BUS:2], 2'b00};
        mem_wd = merge_data;
        mem_we = 1'b1;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  // Control FSM with registered result, error and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= LSU_IDLE;
      addr_reg     <= '0;
      funct3_reg   <= '0;
      wdata_lo_reg <= '0;
      hold_reg     <= '0;
      rdata_reg    <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        LSU_IDLE: begin
          if (accept) begin
            addr_reg     <= addr;
            funct3_reg   <= funct3;
            wdata_lo_reg <= wdata[15:0];
            if (req_err) begin
              // rejected request: no RAM access, zero result
              err_reg   <= 1'b1;
              rdata_reg <= '0;
              done_reg  <= 1'b1;
              state_reg <= LSU_RESP;
            end else if (!req_we) begin
              err_reg   <= 1'b0;
              rdata_reg <= ext_data;
              done_reg  <= 1'b1;
              state_reg <= LSU_RESP;
            end else if (funct3 == F3_W) begin
              // full word written straight through this cycle
              err_reg   <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= LSU_RESP;
            end else begin
              // sub-word store: keep the current word for the merge
              err_reg   <= 1'b0;
              hold_reg  <= mem_rd;
              state_reg <= LSU_RMW_WRITE;
            end
          end
        end
        LSU_RMW_WRITE: begin
          done_reg  <= 1'b1;
          state_reg <= LSU_RESP;
        end
        LSU_RESP: begin
          state_reg <= LSU_IDLE;
        end
        default: begin
          state_reg <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues directed and random
// requests and pushes the expected response computed from a word-array
// model of memory; a monitor pops and compares on every done pulse.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM seen by the DUT: combinational read, whole-word write
  logic [31:0] ram      [0:255];
  logic [31:0] init_val [0:255];
  logic        load_ram;
  assign mem_rd = ram[mem_a[9:2]];
  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val[i];
    end else if (mem_we) begin
      ram[mem_a[9:2]] <= mem_wd;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
    int          nwrites;
    int          wr_cyc;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Legality from the ISA rules: access size per code, alignment by modulo
  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    return (a % size) != 0;
  endfunction

  // Monitor: counts RAM writes between responses and checks each done
  int          nwr = 0;
  int          wr_cyc_seen;
  logic [31:0] wr_data_seen;
  logic [31:0] wr_addr_seen;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (mem_we) begin
      nwr++;
      wr_cyc_seen  = cyc;
      wr_data_seen = mem_wd;
      wr_addr_seen = mem_a;
    end
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("err", {31'd0, err}, {31'd0, mon_e.err});
        check("rdata", rdata, mon_e.rdata);
        check("done_cycle", cyc, mon_e.done_cyc);
        check("write_count", nwr, mon_e.nwrites);
        if (mon_e.nwrites == 1 && nwr == 1) begin
          check("write_cycle", wr_cyc_seen, mon_e.wr_cyc);
          check("write_data", wr_data_seen, mon_e.wr_data);
          check("write_addr", wr_addr_seen, mon_e.wr_addr);
        end
      end
      nwr = 0;
    end
  end

  // Driver: present a request, hold it until accepted, push the expectation
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t        e;
    int          budget;
    int          c;
    int          idx;
    int          sh;
    int          lat;
    logic [31:0] w;
    logic [31:0] s;
    logic [31:0] m;
    logic [31:0] nw;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    budget = 20;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1; req_valid = 1'b0;
      return;
    end
    c   = cyc;
    idx = int'(a[9:2]);
    sh  = 8 * int'(a[1:0]);
    w   = ref_mem[idx];
    s   = w >> sh;
    e.err = model_err(we, f3, a);
    e.nwrites = 0; e.wr_cyc = 0; e.wr_data = 0; e.wr_addr = 0;
    lat = 1;
    if (e.err) begin
      e.rdata = 32'd0;
    end else if (!we) begin
      case (f3)
        3'd0:    e.rdata = {{24{s[7]}}, s[7:0]};
        3'd1:    e.rdata = {{16{s[15]}}, s[15:0]};
        3'd4:    e.rdata = {24'd0, s[7:0]};
        3'd5:    e.rdata = {16'd0, s[15:0]};
        default: e.rdata = w;
      endcase
    end else begin
      if (f3 == 3'd2) begin
        nw = wd;
        e.wr_cyc = c;
      end else begin
        m  = (f3 == 3'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
        nw = (w & ~m) | ((wd << sh) & m);
        e.wr_cyc = c + 1;
        lat = 2;
      end
      e.rdata   = last_rdata;
      e.nwrites = 1;
      e.wr_data = nw;
      e.wr_addr = {a[31:2], 2'b00};
      ref_mem[idx] = nw;
    end
    last_rdata = e.rdata;
    e.done_cyc = c + lat;
    q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int budget;
    int mism;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; load_ram = 1'b1;
    for (int i = 0; i < 256; i++) begin
      init_val[i] = $urandom;
      ref_mem[i]  = init_val[i];
    end
    init_val[4] = 32'h8070_60F0;
    ref_mem[4]  = 32'h8070_60F0;
    last_rdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; load_ram = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_mem_we", {31'd0, mem_we}, 32'd0);

    // Directed cases on the preloaded word 0x10
    issue(1'b0, 3'd0, 32'h10, 32'h0);          // LB
    issue(1'b0, 3'd4, 32'h13, 32'h0);          // LBU
    issue(1'b0, 3'd1, 32'h12, 32'h0);          // LH
    issue(1'b0, 3'd5, 32'h12, 32'h0);          // LHU
    issue(1'b1, 3'd0, 32'h11, 32'h0000_00AB);  // SB
    issue(1'b0, 3'd2, 32'h10, 32'h0);          // LW
    issue(1'b1, 3'd2, 32'h20, 32'h1234_5678);  // SW
    issue(1'b0, 3'd2, 32'h20, 32'h0);          // LW
    issue(1'b1, 3'd1, 32'h21, 32'hDEAD_BEEF);  // SH misaligned
    issue(1'b0, 3'd2, 32'h22, 32'h0);          // LW misaligned
    issue(1'b0, 3'd3, 32'h10, 32'h0);          // illegal load code

    // Reset during the write-back of SH @0x10 aborts the store
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd1; addr = 32'h10; wdata = 32'h0000_5A5A;
    budget = 20;
    @(negedge clk);
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("abort_accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("abort_rmw_not_ready", {31'd0, req_ready}, 32'd0);
    check("abort_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    last_rdata = 32'd0;
    issue(1'b0, 3'd2, 32'h10, 32'h0);          // word 0x10 unchanged

    // Random traffic over the full address space
    for (int n = 0; n < 150; n++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    budget = 50;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("scoreboard_drain", q.size(), 32'd0);
    @(negedge clk);
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    check("ram_final_mismatches", mism, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
